// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: mode encoding and mod-N index helper shared by the stream mux blocks.
package stream_mux_pkg;

    typedef logic mode_t;

    localparam mode_t MODE_FIXED = 1'b0;
    localparam mode_t MODE_RR    = 1'b1;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority arbiter, scanning ptr, ptr+1, ... mod N.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        j         = int'(ptr);
        for (int o = 0; o < N; o++) begin
            if (req[j] && grant == '0) begin
                grant[j]  = 1'b1;
                grant_idx = SELW'(j);
            end
            j = next_idx(j, N);
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux, fixed-select or round-robin,
// feeding a single-entry registered output stage tagged with the source channel.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N-1:0]     rr_grant, fix_grant, grant;
    logic [SELW-1:0]  rr_idx, grant_idx;
    logic             load_en, xfer;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // sel values >= N match no channel, so no grant is made
    always_comb begin
        fix_grant = '0;
        for (int i = 0; i < N; i++) fix_grant[i] = (sel == SELW'(i)) && in_valid[i];
    end

    assign grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
    assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
    assign load_en   = !out_valid_q || out_ready;
    assign in_ready  = (rst_n && load_en) ? grant : '0;
    assign xfer      = |in_ready;

    always_comb begin
        out_valid_d = xfer || (out_valid_q && !out_ready);
        out_data_d  = xfer ? in_data[int'(grant_idx)*WIDTH +: WIDTH] : out_data_q;
        out_chan_d  = xfer ? grant_idx : out_chan_q;
        rr_ptr_d    = (xfer && mode == MODE_RR) ? SELW'(next_idx(int'(grant_idx), N)) : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for stream_mux_rr (N=4 main, plus N=3 and N=5 builds).
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n, mode, out_ready;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;

    logic        r3_n, mode3, out_valid3;
    logic [1:0]  sel3, out_chan3;
    logic [11:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [3:0]  out_data3;

    logic        r5_n, mode5, out_valid5;
    logic [2:0]  sel5, out_chan5;
    logic [19:0] in_data5;
    logic [4:0]  in_valid5, in_ready5;
    logic [3:0]  out_data5;

    int checks = 0;
    int errors = 0;

    int         m_ptr;
    logic       m_ov;
    logic [3:0] m_hd;
    logic [1:0] m_hc;
    logic [5:0] sbq[$];

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(4), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(4), .N(3)) dut3 (
        .clk(clk), .rst_n(r3_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(1'b1)
    );

    stream_mux_rr #(.WIDTH(4), .N(5)) dut5 (
        .clk(clk), .rst_n(r5_n), .mode(mode5), .sel(sel5), .in_data(in_data5),
        .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
        .out_chan(out_chan5), .out_valid(out_valid5), .out_ready(1'b1)
    );

    // One clock of the main DUT: predict grant, push to scoreboard, pop and compare after the edge.
    task automatic step(input string tag);
        int         g;
        logic [3:0] er;
        logic [5:0] e;
        g = -1;
        if (rst_n && (!m_ov || out_ready)) begin
            if (mode) begin
                for (int o = 0; o < 4; o++) begin
                    int j;
                    j = (m_ptr + o) % 4;
                    if (g < 0 && in_valid[j]) g = j;
                end
            end else if (in_valid[sel]) g = int'(sel);
        end
        er = (g >= 0) ? 4'(1 << g) : 4'b0;
        #1;
        checks++;
        if (in_ready !== er) begin
            errors++;
            $display("FAIL %s in_ready got %b exp %b", tag, in_ready, er);
        end
        if (g >= 0) sbq.push_back({2'(g), in_data[g*4 +: 4]});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_ov = 1'b0; m_ptr = 0; m_hd = '0; m_hc = '0;
            sbq.delete();
        end else if (g >= 0) begin
            e = sbq.pop_front();
            m_ov = 1'b1; m_hd = e[3:0]; m_hc = e[5:4];
            if (mode) m_ptr = (g + 1) % 4;
        end else if (out_ready) m_ov = 1'b0;
        checks++;
        if ({out_valid, out_chan, out_data} !== {m_ov, m_hc, m_hd}) begin
            errors++;
            $display("FAIL %s out v/chan/data got %b/%0d/%0d exp %b/%0d/%0d",
                     tag, out_valid, out_chan, out_data, m_ov, m_hc, m_hd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = 4'hf; in_data = 16'h4321; out_ready = 1'b1;
        step("reset");
        step("reset_hold");
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_data = 16'h4321; in_valid = 4'hf;
        step("fixed_sel2");
        checks++;
        if (out_data !== 4'd3 || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL fixed_sel2_const got %0d/%0d exp 3/2", out_data, out_chan);
        end
        sel = 2'd0; step("fixed_sel0");
        sel = 2'd3; step("fixed_sel3");
        sel = 2'd1; in_valid = 4'b1101; step("fixed_sel_invalid");
    endtask

    task automatic test_rr_all();
        logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_n = 1'b0; step("rr_all_rst");
        rst_n = 1'b1; mode = 1'b1; in_valid = 4'hf; in_data = 16'hdcba;
        for (int i = 0; i < 6; i++) begin
            step("rr_all");
            checks++;
            if (out_chan !== seq[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_all_seq[%0d] got chan %0d v %b exp %0d v 1", i, out_chan, out_valid, seq[i]);
            end
        end
    endtask

    task automatic test_rr_sparse();
        mode = 1'b1; in_valid = 4'b1010; in_data = 16'h9876;
        for (int i = 0; i < 4; i++) step("rr_sparse");
        step("rr_sparse_to1");
        in_valid = 4'b0010;
        step("rr_sparse_wrap");
        checks++;
        if (out_chan !== 2'd1) begin
            errors++;
            $display("FAIL rr_sparse_wrap_const got %0d exp 1", out_chan);
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd1; in_data = 16'h5a7b; in_valid = 4'hf; out_ready = 1'b1;
        step("bp_load");
        out_ready = 1'b0; sel = 2'd2; in_data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step("bp_hold");
            checks++;
            if (out_data !== 4'd7 || out_chan !== 2'd1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_const got %0d/%0d/%b exp 7/1/1", out_data, out_chan, out_valid);
            end
        end
        out_ready = 1'b1;
        step("bp_release");
        step("bp_next");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            mode = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            in_valid = 4'($urandom_range(0, 15));
            in_data = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step("random");
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = 4'b0110; in_data = 16'h8421;
        step("mid_prime");
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_prime_valid got %b exp 1", out_valid);
        end
        rst_n = 1'b0;
        step("mid_reset");
        rst_n = 1'b1; in_valid = 4'b1101;
        step("mid_after");
        checks++;
        if (out_chan !== 2'd0) begin
            errors++;
            $display("FAIL mid_after_chan got %0d exp 0", out_chan);
        end
    endtask

    task automatic test_n3();
        logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        mode3 = 1'b1; sel3 = '0; in_valid3 = 3'b111; in_data3 = 12'hcba; r3_n = 1'b0;
        @(posedge clk); #1;
        r3_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_chan3 !== seq[i] || out_valid3 !== 1'b1 || out_data3 !== 4'(10 + seq[i])) begin
                errors++;
                $display("FAIL n3_rr[%0d] got chan %0d data %0d v %b exp %0d", i, out_chan3, out_data3, out_valid3, seq[i]);
            end
        end
    endtask

    task automatic test_sel5();
        mode5 = 1'b0; sel5 = 3'd4; in_valid5 = 5'h1f; in_data5 = 20'h54321; r5_n = 1'b0;
        @(posedge clk); #1;
        r5_n = 1'b1; #1;
        checks++;
        if (in_ready5 !== 5'b10000) begin
            errors++;
            $display("FAIL sel5_ready4 got %b exp 10000", in_ready5);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid5 !== 1'b1 || out_chan5 !== 3'd4 || out_data5 !== 4'd5) begin
            errors++;
            $display("FAIL sel5_load got %b/%0d/%0d exp 1/4/5", out_valid5, out_chan5, out_data5);
        end
        sel5 = 3'd5; #1;
        checks++;
        if (in_ready5 !== 5'b00000) begin
            errors++;
            $display("FAIL sel5_none got %b exp 00000", in_ready5);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid5 !== 1'b0 || out_data5 !== 4'd5 || out_chan5 !== 3'd4) begin
            errors++;
            $display("FAIL sel5_drain got %b/%0d/%0d exp 0/4/5", out_valid5, out_chan5, out_data5);
        end
    endtask

    initial begin
        m_ptr = 0; m_ov = 1'b0; m_hd = '0; m_hc = '0;
        r3_n = 1'b0; mode3 = 1'b0; sel3 = '0; in_valid3 = '0; in_data3 = '0;
        r5_n = 1'b0; mode5 = 1'b0; sel5 = '0; in_valid5 = '0; in_data5 = '0;
        @(negedge clk);
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_n3();
        test_sel5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
